// File: rtl/mux16_scan_pkg.sv
// Shared types and constants for the 16-channel mux scan sequencer.
package mux16_scan_pkg;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StDone
    } scan_state_e;

endpackage

// File: rtl/mux16_next_ch.sv
// Channel order finder: first / next channel of a scan and a last-channel flag.
// With SCAN_MASK_EN defined, masked channels are skipped; otherwise a plain increment.
module mux16_next_ch
    import mux16_scan_pkg::*;
(
`ifdef SCAN_MASK_EN
    input  logic [NUM_CH-1:0] mask,
`endif
    input  logic [SEL_W-1:0]  cur_ch,
    output logic [SEL_W-1:0]  first_ch,
    output logic [SEL_W-1:0]  nxt_ch,
    output logic              any_unmasked,
    output logic              is_last
);

`ifdef SCAN_MASK_EN
    // Descending walk so the lowest qualifying index is the one that sticks.
    always_comb begin
        first_ch     = '0;
        nxt_ch       = cur_ch;
        any_unmasked = 1'b0;
        is_last      = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                first_ch     = SEL_W'(i);
                any_unmasked = 1'b1;
                if (i > int'(cur_ch)) begin
                    nxt_ch  = SEL_W'(i);
                    is_last = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        first_ch     = '0;
        nxt_ch       = cur_ch + SEL_W'(1);
        any_unmasked = 1'b1;
        is_last      = (cur_ch == SEL_W'(NUM_CH - 1));
    end
`endif

endmodule

// File: rtl/mux16_scan_sequencer.sv
// Walks a 16:1 gated mux over its channels, assembles a snapshot, offers it over valid/ready.
// Optional channel masking is enabled by defining SCAN_MASK_EN.
module mux16_scan_sequencer
    import mux16_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter bit          OUT_INV    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    output logic [SEL_W-1:0]  mux_sel,
    output logic              mux_en_n,
    input  logic              mux_out,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_CH-1:0] out_data
`ifdef SCAN_MASK_EN
    ,
    input  logic [NUM_CH-1:0] ch_mask
`endif
);

    localparam logic [CNT_W-1:0] CntReload = CNT_W'(SETTLE_CYC - 1);

    scan_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] shadow_q;
    logic [NUM_CH-1:0] merged;
    logic [SEL_W-1:0]  first_ch;
    logic [SEL_W-1:0]  nxt_ch;
    logic              any_unmasked;
    logic              is_last;
    logic              launch;

`ifdef SCAN_MASK_EN
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] mask_cur;

    // Outside a scan the finder looks at the live mask so the launch edge sees it.
    assign mask_cur = (state_q == StSettle) ? mask_q : ch_mask;
`endif

    mux16_next_ch u_next_ch (
`ifdef SCAN_MASK_EN
        .mask         (mask_cur),
`endif
        .cur_ch       (mux_sel),
        .first_ch     (first_ch),
        .nxt_ch       (nxt_ch),
        .any_unmasked (any_unmasked),
        .is_last      (is_last)
    );

    always_comb begin
        merged          = shadow_q;
        merged[mux_sel] = mux_out ^ OUT_INV;
    end

    assign launch = ((state_q == StIdle) && start) ||
                    ((state_q == StDone) && out_ready && cont);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shadow_q  <= '0;
            mux_sel   <= '0;
            mux_en_n  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef SCAN_MASK_EN
            mask_q    <= '0;
`endif
        end else if (launch) begin
            shadow_q <= '0;
`ifdef SCAN_MASK_EN
            mask_q   <= ch_mask;
`endif
            if (any_unmasked) begin
                state_q   <= StSettle;
                mux_sel   <= first_ch;
                mux_en_n  <= 1'b0;
                busy      <= 1'b1;
                cnt_q     <= CntReload;
                out_valid <= 1'b0;
            end else begin
                // Everything masked: the empty snapshot is ready immediately.
                state_q   <= StDone;
                mux_sel   <= '0;
                mux_en_n  <= 1'b1;
                busy      <= 1'b0;
                out_valid <= 1'b1;
                out_data  <= '0;
            end
        end else begin
            unique case (state_q)
                StSettle: begin
                    if (abort) begin
                        state_q  <= StIdle;
                        mux_sel  <= '0;
                        mux_en_n <= 1'b1;
                        busy     <= 1'b0;
                        shadow_q <= '0;
                    end else if (cnt_q == '0) begin
                        shadow_q <= merged;
                        if (is_last) begin
                            state_q   <= StDone;
                            out_data  <= merged;
                            out_valid <= 1'b1;
                            mux_en_n  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            mux_sel <= nxt_ch;
                            cnt_q   <= CntReload;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_scan_sequencer.sv
// Self-checking bench for mux16_scan_sequencer: vector table, directed corner cases, random scans.
module tb_mux16_scan_sequencer;

    localparam int unsigned SC  = 2;
    localparam bit          INV = 1'b1;

    logic        clk = 1'b0;
    logic        rst, start, cont, abort, out_ready;
    logic [3:0]  mux_sel;
    logic        mux_en_n, mux_out, busy, out_valid;
    logic [15:0] out_data;
    logic [15:0] data;
    logic [15:0] cur_mask;
`ifdef SCAN_MASK_EN
    logic [15:0] ch_mask;
`endif

    always #5 clk = ~clk;

    // Gated mux model; inverting to match OUT_INV.
    assign mux_out = mux_en_n ? 1'b1 : (data[mux_sel] ^ INV);

    mux16_scan_sequencer #(
        .SETTLE_CYC (SC),
        .OUT_INV    (INV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .abort     (abort),
        .mux_sel   (mux_sel),
        .mux_en_n  (mux_en_n),
        .mux_out   (mux_out),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SCAN_MASK_EN
        ,
        .ch_mask   (ch_mask)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int sel_q[$];
    logic first_busy;
    int en_bad;

    typedef struct {
        logic [15:0] d;
        int          rdy_dly;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_scan(input logic [15:0] d);
        @(negedge clk);
        data = d;
`ifdef SCAN_MASK_EN
        ch_mask = cur_mask;
`endif
        start = 1'b1;
    endtask

    // Waits for out_valid; lat = cycles from the launching edge to out_valid.
    task automatic wait_valid(input bit noise, output int lat);
        int cyc = 0;
        sel_q.delete();
        en_bad = 0;
        lat = -1;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            out_ready = 1'b0;
            if (cyc == 1) first_busy = busy;
            if (mux_en_n !== ~busy) en_bad++;
            if (out_valid) begin
                lat = cyc - 1;
                break;
            end
            if (busy) sel_q.push_back(int'(mux_sel));
            if (noise) start = ($urandom_range(3) == 0);
        end
        if (lat < 0) check("valid_timeout", 32'(out_valid), 32'(1));
    endtask

    // Model: every unmasked channel in ascending order, each held SC cycles.
    task automatic check_scan(input int lat);
        int exp_sel[$];
        int bad = 0;
        for (int ch = 0; ch < 16; ch++)
            if (!cur_mask[ch]) for (int k = 0; k < int'(SC); k++) exp_sel.push_back(ch);
        check("latency", 32'(lat), 32'(exp_sel.size()));
        if (sel_q.size() != exp_sel.size()) bad = 1;
        else for (int i = 0; i < sel_q.size(); i++) if (sel_q[i] != exp_sel[i]) bad++;
        check("sel_seq", 32'(bad), 32'(0));
        check("en_vs_busy", 32'(en_bad), 32'(0));
    endtask

    task automatic handshake(input int delay, input logic [15:0] exp);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_data", 32'(out_data), 32'(exp));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_valid", 32'(out_valid), 32'(0));
        check("hs_busy", 32'(busy), 32'(0));
        check("hs_en_n", 32'(mux_en_n), 32'(1));
        check("hs_keep", 32'(out_data), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [15:0] prev;
        rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; out_ready = 1'b0;
        data = '0; cur_mask = '0;
`ifdef SCAN_MASK_EN
        ch_mask = '0;
`endif
        vecs[0] = '{16'hA5C3, 0, 16'hA5C3};
        vecs[1] = '{16'h00FF, 2, 16'h00FF};
        vecs[2] = '{16'h1234, 1, 16'h1234};
        vecs[3] = '{16'h8001, 3, 16'h8001};
        vecs[4] = '{16'h0000, 0, 16'h0000};
        vecs[5] = '{16'hFFFF, 1, 16'hFFFF};

        repeat (3) @(negedge clk);
        check("rst_sel", 32'(mux_sel), 32'(0));
        check("rst_en_n", 32'(mux_en_n), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_scan(vecs[i].d);
            wait_valid(1'b0, lat);
            check_scan(lat);
            check("tbl_data", 32'(out_data), 32'(vecs[i].exp));
            handshake(vecs[i].rdy_dly, vecs[i].exp);
        end

        // Backpressure with a start pulse during DONE
        start_scan(16'hA5C3);
        wait_valid(1'b0, lat);
        check("bp_data", 32'(out_data), 32'hA5C3);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = (k == 3);
            check("bp_valid", 32'(out_valid), 32'(1));
            check("bp_hold", 32'(out_data), 32'hA5C3);
            check("bp_busy", 32'(busy), 32'(0));
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp_idle_valid", 32'(out_valid), 32'(0));
            check("bp_idle_busy", 32'(busy), 32'(0));
            @(negedge clk);
        end

        // Abort at channel 5
        start_scan(16'h00FF);
        wait_valid(1'b0, lat);
        check("ab_first", 32'(out_data), 32'h00FF);
        handshake(0, 16'h00FF);
        start_scan(16'h1234);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && mux_sel == 4'd5) break;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", 32'(busy), 32'(0));
        check("ab_en_n", 32'(mux_en_n), 32'(1));
        check("ab_valid", 32'(out_valid), 32'(0));
        check("ab_data", 32'(out_data), 32'h00FF);
        check("ab_sel", 32'(mux_sel), 32'(0));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_idle_busy", 32'(busy), 32'(0));
        start_scan(16'h1234);
        wait_valid(1'b0, lat);
        check_scan(lat);
        check("ab_rescan", 32'(out_data), 32'h1234);
        handshake(0, 16'h1234);

        // Continuous mode: restart on the handshake edge
        cont = 1'b1;
        start_scan(16'h1234);
        wait_valid(1'b0, lat);
        check("cont_first", 32'(out_data), 32'h1234);
        out_ready = 1'b1;
        data = 16'h8001;
        wait_valid(1'b0, lat);
        check("cont_no_idle", 32'(first_busy), 32'(1));
        check_scan(lat);
        check("cont_second", 32'(out_data), 32'h8001);
        cont = 1'b0;
        handshake(2, 16'h8001);

        // Async glitch ignored, then synchronous reset mid-scan
        start_scan(16'h5A5A);
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        check("glitch_busy", 32'(busy), 32'(1));
        check("glitch_en_n", 32'(mux_en_n), 32'(0));
        check("glitch_data", 32'(out_data), 32'h8001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_sel", 32'(mux_sel), 32'(0));
        check("mrst_en_n", 32'(mux_en_n), 32'(1));
        check("mrst_busy", 32'(busy), 32'(0));
        check("mrst_valid", 32'(out_valid), 32'(0));
        check("mrst_data", 32'(out_data), 32'(0));

`ifdef SCAN_MASK_EN
        cur_mask = 16'hFFF0;
        start_scan(16'hFFFF);
        wait_valid(1'b0, lat);
        check_scan(lat);
        check("mask_data", 32'(out_data), 32'h000F);
        handshake(0, 16'h000F);
        cur_mask = 16'hFFFF;
        start_scan(16'hFFFF);
        wait_valid(1'b0, lat);
        check_scan(lat);
        check("mask_all", 32'(out_data), 32'(0));
        handshake(0, 16'h0000);
        cur_mask = '0;
`endif

        // Random scans with random aborts, backpressure and ignored start pulses
        prev = 16'h0000;
        for (int it = 0; it < 20; it++) begin
            logic [15:0] d;
            logic        do_ab;
            logic [3:0]  ach;
            d     = 16'($urandom);
            do_ab = ($urandom_range(3) == 0);
            ach   = 4'($urandom_range(15));
            start_scan(d);
            if (do_ab) begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    start = 1'b0;
                    if (busy && mux_sel == ach) break;
                end
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("rnd_ab_valid", 32'(out_valid), 32'(0));
                check("rnd_ab_busy", 32'(busy), 32'(0));
                check("rnd_ab_data", 32'(out_data), 32'(prev));
            end else begin
                wait_valid(1'b1, lat);
                check_scan(lat);
                check("rnd_data", 32'(out_data), 32'(d));
                handshake(int'($urandom_range(3)), d);
                prev = d;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux16_scan_sequencer.md
Name: mux16_scan_sequencer

Overview:
Sequencing controller for the 16:1 gated multiplexer datapath: 4-bit select, active-low enable, single output.
- Walks the select lines over all 16 channels and holds each select until the mux output has settled.
- Samples the mux output for each channel and assembles a 16-bit snapshot.
- Hands the snapshot to a consumer over a valid/ready interface.
- Sits between the mux netlist and any block that needs parallel access to the 16 mux data inputs.

Parameters:
SETTLE_CYC, 2, cycles each select value is held before its sample (legal range 1..15)
OUT_INV, 1, 1 = mux output is inverted (captured bit = ~mux_out); 0 = non-inverting

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request one scan; honoured only in IDLE
cont  in  1  continuous mode; sampled when a snapshot is accepted
abort  in  1  synchronous abort of an in-progress scan
mux_sel  out  4  select lines to mux (LSB = first select input)
mux_en_n  out  1  active-low mux enable
mux_out  in  1  mux output
busy  out  1  high in SETTLE
out_valid  out  1  snapshot available
out_ready  in  1  consumer accepts snapshot
out_data  out  16  snapshot; bit k = channel k

Behaviour:
- Reset (rst=1 at an edge) overrides everything:
  - state=IDLE, mux_sel=0, mux_en_n=1, busy=0, out_valid=0, out_data=0, shadow=0, counter=0.
- States are IDLE, SETTLE, DONE.
- IDLE:
  - mux_en_n=1.
  - On start=1: go to SETTLE, mux_sel=first channel, mux_en_n=0, cnt=SETTLE_CYC-1.
- SETTLE, on each edge:
  - abort=1 has priority: go to IDLE, mux_en_n=1, mux_sel=0, shadow discarded, out_data unchanged.
  - Else if cnt==0:
    - shadow[mux_sel] = mux_out ^ OUT_INV.
    - If mux_sel is the last channel: out_data=shadow with the new bit merged, out_valid=1, mux_en_n=1, go to DONE.
    - Otherwise: mux_sel=next channel, cnt=SETTLE_CYC-1.
  - Else cnt=cnt-1.
- Timing:
  - Each channel is held exactly SETTLE_CYC cycles.
  - A full unmasked scan asserts out_valid 16*SETTLE_CYC cycles after the start edge.
- DONE:
  - out_valid=1 and out_data stable until out_valid&&out_ready.
  - On handshake: if cont=1, re-enter SETTLE directly (same as start, no IDLE cycle); else go to IDLE with out_valid=0.
  - out_data keeps its last value after the handshake.
- Ignored inputs:
  - start is ignored in SETTLE and DONE (no queuing).
  - abort is ignored in IDLE and DONE.
- mux_sel wraps 15->0 only through a new scan, never inside a scan.
- mux_sel and mux_en_n are registered outputs, glitch-free.

Optional Feature:
SCAN_MASK_EN
- Defined:
  - Adds input ch_mask[15:0], captured at scan start (start or continuous restart).
  - Masked channels are skipped (zero cycles) and their result bits are forced to 0.
  - "First", "next" and "last" refer to unmasked channels only.
  - ch_mask=16'hFFFF: go straight to DONE on the start edge with out_data=0; out_valid is high the next cycle.
- Undefined: no ch_mask port; all 16 channels are always scanned in order 0..15.

Decomposition:
- Shared package mux16_scan_pkg:
  - state enum (IDLE/SETTLE/DONE);
  - NUM_CH=16 and SEL_W=4 constants;
  - settle counter width.
- One natural sub-module, mux16_next_ch: combinational priority finder returning the next/first unmasked channel and a last flag. It is a trivial increment when SCAN_MASK_EN is off.

Test Plan:
- Basic scan, SETTLE_CYC=2, OUT_INV=0:
  - Stimulus: mux data = 16'hA5C3 behind a mux model, start pulse.
  - Response: mux_sel steps 0..15, each held 2 cycles; out_valid rises 32 cycles after start; out_data=16'hA5C3.
- OUT_INV=1 with inverting mux model, same data: out_data=16'hA5C3; mux_en_n=0 only while busy.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles, then 1; pulse start during DONE.
  - Response: out_valid and out_data held; start ignored; IDLE after handshake.
- Abort:
  - Stimulus: complete one scan (out_data=16'h00FF), then start a second scan and assert abort at its channel 5.
  - Response: IDLE next cycle, mux_en_n=1, out_valid=0, out_data still 16'h00FF.
- Continuous mode, cont=1:
  - Stimulus: data changes 16'h1234 -> 16'h8001 between scans; cont=1 throughout.
  - Response: second scan starts on the handshake edge with no IDLE cycle; consecutive snapshots are 16'h1234 then 16'h8001.
- SCAN_MASK_EN:
  - Stimulus: ch_mask=16'hFFF0, data=16'hFFFF.
  - Response: out_valid after 4*SETTLE_CYC cycles; out_data=16'h000F.
  - Stimulus: ch_mask=16'hFFFF.
  - Response: out_valid one cycle after start; out_data=0.
- Synchronous rst mid-SETTLE: all outputs at reset values on the next edge; an asynchronous-only glitch on rst has no effect.
